instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have port: pc_in  in  8  current PC from program counter.
REQ-004 SHALL have port: mem_rdata  in  8  instruction memory read data, combinational from mem_addr.
REQ-005 SHALL have port: mem_addr  out  8  instruction memory address.
REQ-006 SHALL have port: pc_write  out  1  PC update strobe (increment, or vector load when load_vector=1).
REQ-007 SHALL have port: load_vector  out  1  PC loads mem_rdata instead of PC+1.
REQ-008 SHALL have port: irq  in  1  level interrupt request.
REQ-009 SHALL have port: irq_ack  out  1  one-cycle pulse on interrupt vector load.
REQ-010 SHALL have port: ret_pc  out  8  PC captured at interrupt entry, for decode/stack.
REQ-011 SHALL have port: redirect  in  1  taken branch/jump/RTI from execute; flush fetch.
REQ-012 SHALL have port: ir_out  out  8  opcode byte.
REQ-013 SHALL have port: imm_out  out  8  second byte of 2-byte instruction; holds last value otherwise.
REQ-014 SHALL have port: ir_valid  out  1  ir_out/imm_out hold a complete instruction.
REQ-015 SHALL have port: ir_ready  in  1  decode accepts instruction when ir_valid and ir_ready both high.

Function
REQ-016 SHALL implement states RST_VEC, FETCH, FETCH_OP2, HOLD, INT_VEC.
REQ-017 RST_VEC: mem_addr=0x00, pc_write=1, load_vector=1 for exactly one cycle, then FETCH.
REQ-018 FETCH: mem_addr=pc_in, ir_out<=mem_rdata, pc_write=1, load_vector=0.
REQ-019 FETCH exit: mem_rdata[7:4]==4'hC (2-byte, LDM class) -> FETCH_OP2; otherwise -> HOLD.
REQ-020 FETCH_OP2: mem_addr=pc_in, imm_out<=mem_rdata, pc_write=1, then HOLD; total PC advance +2.
REQ-021 HOLD: ir_valid=1, pc_write=0; ir_ready=1 -> FETCH next cycle; ir_ready=0 -> stay, ir_out/imm_out stable.
REQ-022 ir_valid SHALL be 1 only in HOLD; latency from FETCH entry to ir_valid is 1 cycle (1-byte) or 2 cycles (2-byte).
REQ-023 INT_VEC: mem_addr=0x01, pc_write=1, load_vector=1, irq_ack=1 for one cycle, then FETCH.
REQ-024 Interrupt SHALL be taken only when in FETCH with irq=1 (instruction boundary); FETCH then goes to INT_VEC, ret_pc<=pc_in, no ir_out update, no increment.
REQ-025 redirect=1 in any state except RST_VEC SHALL force pc_write=0, load_vector=0, ir_valid=0 that cycle and next state FETCH; partial/held instruction discarded.
REQ-026 Priority: rst > RST_VEC sequence > redirect > irq > normal sequencing.
REQ-027 irq arriving during FETCH_OP2 or HOLD SHALL wait until the next FETCH.
REQ-028 Address arithmetic 8-bit; pc_in=0xFF fetch followed by PC wrap to 0x00 handled without special case.
REQ-029 pc_write and load_vector SHALL be registered-state decodes, glitch-free within the cycle, never asserted outside listed states.

Reset
REQ-030 rst=1 SHALL asynchronously force state RST_VEC, ir_out=0x00, imm_out=0x00, ret_pc=0x00, ir_valid=0, irq_ack=0.
REQ-031 rst asserted mid-instruction SHALL discard it; after release the first cycle is RST_VEC.

Configuration
REQ-032 Macro FETCH_IRQ_EN defined: REQ-023/024/027 active.
REQ-033 FETCH_IRQ_EN undefined: irq ignored, INT_VEC absent, irq_ack=0 and ret_pc=0x00 constantly.

Verification
REQ-034 Reset release, M[0]=0x10 -> cycle 1 mem_addr=0x00, pc_write=1, load_vector=1; next cycle mem_addr=0x10.
REQ-035 pc_in=0x10, mem_rdata=0x25, ir_ready=1 -> ir_out=0x25, ir_valid one cycle, one pc_write pulse.
REQ-036 pc_in=0x11 byte 0xC3 then 0x7A -> two pc_write pulses, ir_out=0xC3, imm_out=0x7A, then ir_valid.
REQ-037 ir_ready=0 for 3 cycles in HOLD -> ir_valid stays 1, outputs stable, no pc_write.
REQ-038 irq=1 at FETCH with pc_in=0x51, M[1]=0x80 -> INT_VEC: mem_addr=0x01, load_vector=1, irq_ack=1, ret_pc=0x51; without FETCH_IRQ_EN normal fetch at 0x51.
REQ-039 redirect=1 during FETCH_OP2 -> no pc_write, ir_valid=0, next cycle FETCH at new pc_in=0x50.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: byte-wide instruction fetch sequencer with 1/2-byte decode and decode handshake.
// Define FETCH_IRQ_EN to enable interrupt entry (INT_VEC, irq_ack, ret_pc capture).
module instr_fetch (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pc_in,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_addr,
    output logic       pc_write,
    output logic       load_vector,
    input  logic       irq,
    output logic       irq_ack,
    output logic [7:0] ret_pc,
    input  logic       redirect,
    output logic [7:0] ir_out,
    output logic [7:0] imm_out,
    output logic       ir_valid,
    input  logic       ir_ready
);
    // state     | meaning
    // RST_VEC   | load PC from vector 0x00, one cycle after reset
    // FETCH     | fetch opcode at pc_in, instruction boundary (irq sampled here)
    // FETCH_OP2 | fetch immediate byte of a 2-byte instruction
    // HOLD      | instruction presented to decode until ir_ready
    // INT_VEC   | load PC from vector 0x01, acknowledge interrupt
    localparam logic [2:0] S_RST_VEC   = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_FETCH_OP2 = 3'd2;
    localparam logic [2:0] S_HOLD      = 3'd3;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_ir;
    logic [7:0] r_imm;
    logic       w_irq_take;
    logic       w_two_byte;

    assign w_two_byte = (mem_rdata[7:4] == 4'hC);

`ifdef FETCH_IRQ_EN
    localparam logic [2:0] S_INT_VEC = 3'd4;
    logic [7:0] r_ret_pc;

    assign w_irq_take = (r_state == S_FETCH) && irq && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ret_pc <= 8'h00;
        else if (w_irq_take)
            r_ret_pc <= pc_in;
    end

    assign ret_pc = r_ret_pc;
`else
    // Interrupts compiled out: irq is deliberately ignored.
    assign w_irq_take = irq & 1'b0;
    assign ret_pc     = 8'h00;
`endif

    always_comb begin
        mem_addr    = pc_in;
        pc_write    = 1'b0;
        load_vector = 1'b0;
        irq_ack     = 1'b0;
        ir_valid    = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_RST_VEC: begin
                mem_addr    = 8'h00;
                pc_write    = 1'b1;
                load_vector = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (redirect) begin
                    w_state_nxt = S_FETCH;
                end else if (w_irq_take) begin
`ifdef FETCH_IRQ_EN
                    w_state_nxt = S_INT_VEC;
`else
                    w_state_nxt = S_FETCH;
`endif
                end else begin
                    pc_write    = 1'b1;
                    w_state_nxt = w_two_byte ? S_FETCH_OP2 : S_HOLD;
                end
            end
            S_FETCH_OP2: begin
                if (redirect) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    pc_write    = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    ir_valid = 1'b1;
                    if (ir_ready)
                        w_state_nxt = S_FETCH;
                end
            end
`ifdef FETCH_IRQ_EN
            S_INT_VEC: begin
                mem_addr    = 8'h01;
                w_state_nxt = S_FETCH;
                if (!redirect) begin
                    pc_write    = 1'b1;
                    load_vector = 1'b1;
                    irq_ack     = 1'b1;
                end
            end
`endif
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RST_VEC;
            r_ir    <= 8'h00;
            r_imm   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_FETCH && pc_write)
                r_ir <= mem_rdata;
            if (r_state == S_FETCH_OP2 && pc_write)
                r_imm <= mem_rdata;
        end
    end

    assign ir_out  = r_ir;
    assign imm_out = r_imm;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized program stream against an instruction-level model.
`timescale 1ns/1ps
module tb_instr_fetch;
    logic       clk = 1'b0;
    logic       rst, irq, redirect, ir_ready;
    logic [7:0] pc_in, mem_rdata, mem_addr, ret_pc, ir_out, imm_out;
    logic       pc_write, load_vector, irq_ack, ir_valid;
    logic [7:0] mem [256];
    logic [7:0] redirect_pc;
    int         n_cmp = 0;
    int         n_fail = 0;

    instr_fetch dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .pc_write(pc_write), .load_vector(load_vector), .irq(irq), .irq_ack(irq_ack),
        .ret_pc(ret_pc), .redirect(redirect), .ir_out(ir_out), .imm_out(imm_out),
        .ir_valid(ir_valid), .ir_ready(ir_ready)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Program counter stand-in: execute redirect wins, otherwise follow fetch strobes.
    always @(posedge clk) begin
        if (redirect)
            pc_in <= redirect_pc;
        else if (pc_write)
            pc_in <= load_vector ? mem_rdata : pc_in + 8'd1;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ir_valid got=%0h exp=0", ir_valid); end
        n_cmp++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL rst_irq_ack got=%0h exp=0", irq_ack); end
        n_cmp++; if (ret_pc !== 8'h00) begin n_fail++; $display("FAIL rst_ret_pc got=%0h exp=00", ret_pc); end
        n_cmp++; if (ir_out !== 8'h00) begin n_fail++; $display("FAIL rst_ir_out got=%0h exp=00", ir_out); end
        n_cmp++; if (imm_out !== 8'h00) begin n_fail++; $display("FAIL rst_imm_out got=%0h exp=00", imm_out); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL rstvec_addr got=%0h exp=00", mem_addr); end
        n_cmp++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL rstvec_pc_write got=%0h exp=1", pc_write); end
        n_cmp++; if (load_vector !== 1'b1) begin n_fail++; $display("FAIL rstvec_load_vector got=%0h exp=1", load_vector); end
        tick;
        n_cmp++; if (mem_addr !== 8'h10) begin n_fail++; $display("FAIL first_fetch_addr got=%0h exp=10", mem_addr); end
        n_cmp++; if (load_vector !== 1'b0) begin n_fail++; $display("FAIL first_fetch_lv got=%0h exp=0", load_vector); end
    endtask

    task automatic test_single;
        int writes;
        writes = 0;
        if (pc_write === 1'b1) writes++;
        n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL single_fetch_valid got=%0h exp=0", ir_valid); end
        tick;
        if (pc_write === 1'b1) writes++;
        n_cmp++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%0h exp=1", ir_valid); end
        n_cmp++; if (ir_out !== 8'h25) begin n_fail++; $display("FAIL single_ir got=%0h exp=25", ir_out); end
        tick;
        n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop got=%0h exp=0", ir_valid); end
        n_cmp++; if (writes != 1) begin n_fail++; $display("FAIL single_pc_writes got=%0d exp=1", writes); end
        n_cmp++; if (mem_addr !== 8'h11) begin n_fail++; $display("FAIL single_next_addr got=%0h exp=11", mem_addr); end
    endtask

    task automatic test_two_byte_hold;
        n_cmp++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL two_op1_write got=%0h exp=1", pc_write); end
        ir_ready = 1'b0;
        tick;
        n_cmp++; if (mem_addr !== 8'h12) begin n_fail++; $display("FAIL two_op2_addr got=%0h exp=12", mem_addr); end
        n_cmp++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL two_op2_write got=%0h exp=1", pc_write); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL two_op2_valid got=%0h exp=0", ir_valid); end
        tick;
        n_cmp++; if (ir_out !== 8'hC3 || imm_out !== 8'h7A) begin n_fail++; $display("FAIL two_regs got=%0h/%0h exp=c3/7a", ir_out, imm_out); end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++;
            if (ir_valid !== 1'b1 || pc_write !== 1'b0 || ir_out !== 8'hC3 || imm_out !== 8'h7A) begin
                n_fail++;
                $display("FAIL hold_stall valid=%0h wr=%0h ir=%0h imm=%0h exp=1/0/c3/7a", ir_valid, pc_write, ir_out, imm_out);
            end
        end
        ir_ready = 1'b1;
        tick;
        n_cmp++; if (mem_addr !== 8'h13 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL two_next addr=%0h valid=%0h exp=13/0", mem_addr, ir_valid); end
    endtask

    task automatic test_irq;
        redirect = 1'b1;
        redirect_pc = 8'h51;
        #1;
        n_cmp++; if (pc_write !== 1'b0 || load_vector !== 1'b0 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL redir_fetch wr=%0h lv=%0h v=%0h exp=0/0/0", pc_write, load_vector, ir_valid); end
        tick;
        redirect = 1'b0;
        irq = 1'b1;
        #1;
`ifdef FETCH_IRQ_EN
        n_cmp++; if (pc_write !== 1'b0 || mem_addr !== 8'h51) begin n_fail++; $display("FAIL irq_fetch wr=%0h addr=%0h exp=0/51", pc_write, mem_addr); end
        tick;
        irq = 1'b0;
        n_cmp++; if (mem_addr !== 8'h01 || load_vector !== 1'b1 || irq_ack !== 1'b1 || pc_write !== 1'b1) begin n_fail++; $display("FAIL int_vec addr=%0h lv=%0h ack=%0h wr=%0h exp=01/1/1/1", mem_addr, load_vector, irq_ack, pc_write); end
        n_cmp++; if (ret_pc !== 8'h51) begin n_fail++; $display("FAIL ret_pc got=%0h exp=51", ret_pc); end
        tick;
        n_cmp++; if (mem_addr !== 8'h80 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL isr_fetch addr=%0h ack=%0h exp=80/0", mem_addr, irq_ack); end
        ir_ready = 1'b0;
        tick;
        irq = 1'b1;
        tick;
        n_cmp++; if (irq_ack !== 1'b0 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL irq_in_hold ack=%0h valid=%0h exp=0/1", irq_ack, ir_valid); end
        ir_ready = 1'b1;
        tick;
        n_cmp++; if (pc_write !== 1'b0 || mem_addr !== 8'h81) begin n_fail++; $display("FAIL irq_deferred wr=%0h addr=%0h exp=0/81", pc_write, mem_addr); end
        irq = 1'b0;
        tick;
        n_cmp++; if (irq_ack !== 1'b1 || ret_pc !== 8'h81) begin n_fail++; $display("FAIL irq_deferred_ack ack=%0h ret=%0h exp=1/81", irq_ack, ret_pc); end
        tick;
`else
        n_cmp++; if (pc_write !== 1'b1 || mem_addr !== 8'h51 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL noirq_fetch wr=%0h addr=%0h ack=%0h exp=1/51/0", pc_write, mem_addr, irq_ack); end
        tick;
        n_cmp++; if (ir_out !== 8'h07 || ret_pc !== 8'h00 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL noirq_hold ir=%0h ret=%0h ack=%0h exp=07/00/0", ir_out, ret_pc, irq_ack); end
        irq = 1'b0;
        tick;
        n_cmp++; if (mem_addr !== 8'h52) begin n_fail++; $display("FAIL noirq_next addr=%0h exp=52", mem_addr); end
`endif
    endtask

    task automatic test_redirect;
        redirect = 1'b1;
        redirect_pc = 8'h30;
        tick;
        redirect = 1'b0;
        tick;
        redirect = 1'b1;
        redirect_pc = 8'h50;
        #1;
        n_cmp++; if (pc_write !== 1'b0 || load_vector !== 1'b0 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL redir_op2 wr=%0h lv=%0h v=%0h exp=0/0/0", pc_write, load_vector, ir_valid); end
        tick;
        redirect = 1'b0;
        #1;
        n_cmp++; if (mem_addr !== 8'h50 || pc_write !== 1'b1) begin n_fail++; $display("FAIL redir_refetch addr=%0h wr=%0h exp=50/1", mem_addr, pc_write); end
        n_cmp++; if (imm_out !== 8'h7A) begin n_fail++; $display("FAIL redir_imm_kept got=%0h exp=7a", imm_out); end
        tick;
        redirect = 1'b1;
        redirect_pc = 8'h60;
        #1;
        n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL redir_hold_valid got=%0h exp=0", ir_valid); end
        tick;
        redirect = 1'b0;
        #1;
        n_cmp++; if (mem_addr !== 8'h60 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL redir_hold_next addr=%0h v=%0h exp=60/0", mem_addr, ir_valid); end
    endtask

    task automatic test_wrap;
        redirect = 1'b1;
        redirect_pc = 8'hFF;
        tick;
        redirect = 1'b0;
        #1;
        n_cmp++; if (mem_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_op1 addr=%0h exp=ff", mem_addr); end
        tick;
        n_cmp++; if (mem_addr !== 8'h00 || pc_write !== 1'b1) begin n_fail++; $display("FAIL wrap_op2 addr=%0h wr=%0h exp=00/1", mem_addr, pc_write); end
        tick;
        n_cmp++; if (ir_out !== 8'hC9 || imm_out !== 8'h10 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_hold ir=%0h imm=%0h v=%0h exp=c9/10/1", ir_out, imm_out, ir_valid); end
        tick;
        n_cmp++; if (mem_addr !== 8'h01) begin n_fail++; $display("FAIL wrap_next addr=%0h exp=01", mem_addr); end
    endtask

    task automatic test_mid_reset;
        redirect = 1'b1;
        redirect_pc = 8'h30;
        tick;
        redirect = 1'b0;
        tick;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (ir_valid !== 1'b0 || ir_out !== 8'h00 || imm_out !== 8'h00) begin n_fail++; $display("FAIL midrst_regs v=%0h ir=%0h imm=%0h exp=0/00/00", ir_valid, ir_out, imm_out); end
        n_cmp++; if (mem_addr !== 8'h00 || load_vector !== 1'b1) begin n_fail++; $display("FAIL midrst_state addr=%0h lv=%0h exp=00/1", mem_addr, load_vector); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (mem_addr !== 8'h00 || pc_write !== 1'b1 || load_vector !== 1'b1) begin n_fail++; $display("FAIL midrst_vec addr=%0h wr=%0h lv=%0h exp=00/1/1", mem_addr, pc_write, load_vector); end
        tick;
        n_cmp++; if (mem_addr !== 8'h10) begin n_fail++; $display("FAIL midrst_fetch addr=%0h exp=10", mem_addr); end
    endtask

    task automatic test_random;
        logic [7:0] start, model_pc, exp_ir, exp_imm;
        int accepted;
        start = 8'($urandom_range(32, 127));
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            if ($urandom_range(0, 2) == 0) mem[i][7:4] = 4'hC;
        end
        mem[start][7:4] = 4'hC;
        redirect = 1'b1;
        redirect_pc = start;
        tick;
        redirect = 1'b0;
        model_pc = start;
        exp_imm = 8'h00;
        accepted = 0;
        for (int c = 0; c < 300; c++) begin
            ir_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (ir_valid === 1'b1 && ir_ready) begin
                exp_ir = mem[model_pc];
                if (exp_ir[7:4] == 4'hC) begin
                    exp_imm = mem[model_pc + 8'd1];
                    model_pc = model_pc + 8'd2;
                end else begin
                    model_pc = model_pc + 8'd1;
                end
                n_cmp++;
                if (ir_out !== exp_ir || imm_out !== exp_imm) begin
                    n_fail++;
                    $display("FAIL rand_instr#%0d got=%0h/%0h exp=%0h/%0h", accepted, ir_out, imm_out, exp_ir, exp_imm);
                end
                accepted++;
            end
            tick;
        end
        ir_ready = 1'b1;
        n_cmp++; if (accepted < 40) begin n_fail++; $display("FAIL rand_throughput got=%0d exp>=40", accepted); end
    endtask

    initial begin
        rst = 1'b1;
        irq = 1'b0;
        redirect = 1'b0;
        ir_ready = 1'b1;
        redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h10;
        mem[8'h01] = 8'h80;
        mem[8'h10] = 8'h25;
        mem[8'h11] = 8'hC3;
        mem[8'h12] = 8'h7A;
        mem[8'h30] = 8'hC5;
        mem[8'h31] = 8'h99;
        mem[8'h51] = 8'h07;
        mem[8'hFF] = 8'hC9;
        test_reset;
        test_single;
        test_two_byte_hold;
        test_irq;
        test_redirect;
        test_wrap;
        test_mid_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
